// File: rtl/game_pay_ctrl_pkg.sv
// Shared definitions for the payment/session controller and the play counter it drives:
// state encodings, default widths/limits and the coin-to-credit helper.
package game_pay_ctrl_pkg;

    localparam int MONEY_W_DEF    = 10;
    localparam int MAX_CREDIT_DEF = 999;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_PLAY = 3'd3,
        ST_OVER = 3'd4
    } state_e;

    // Credit value of one cycle's coin pulses; both together give 6.
    function automatic logic [2:0] coin_value(input logic c1, input logic c5);
        return (c5 ? 3'd5 : 3'd0) + (c1 ? 3'd1 : 3'd0);
    endfunction

endpackage

// File: rtl/game_credit_acc.sv
// Saturating credit accumulator. clr drops the held credit but still adds this
// cycle's coins, so no coin is lost when credit is spent.
module game_credit_acc
    import game_pay_ctrl_pkg::*;
#(
    parameter int MONEY_W    = MONEY_W_DEF,
    parameter int MAX_CREDIT = MAX_CREDIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [2:0]         add,
    output logic [MONEY_W-1:0] credit
);

    localparam logic [MONEY_W:0] MAX_EXT = (MONEY_W + 1)'(MAX_CREDIT);

    logic [MONEY_W:0]   base;
    logic [MONEY_W:0]   sum;
    logic [MONEY_W-1:0] credit_d;

    always_comb begin
        base     = clr ? '0 : {1'b0, credit};
        sum      = base + {{(MONEY_W - 2){1'b0}}, add};
        credit_d = (sum > MAX_EXT) ? MAX_EXT[MONEY_W-1:0] : sum[MONEY_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else begin
            credit <= credit_d;
        end
    end

endmodule

// File: rtl/game_pay_ctrl.sv
// Payment/session controller: turns coin credit into load pulses for game_count,
// drives boost during play and holds a fixed OVER period before returning to IDLE.
module game_pay_ctrl
    import game_pay_ctrl_pkg::*;
#(
    parameter int MONEY_W    = MONEY_W_DEF,
    parameter int MAX_CREDIT = MAX_CREDIT_DEF,
    parameter int MIN_START  = 10,
    parameter int OVER_CYC   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coin1,
    input  logic               coin5,
    input  logic               start,
    input  logic               boost_req,
    input  logic               red,
    input  logic               yellow,
    input  logic [MONEY_W-1:0] remain,
    output logic               set,
    output logic [MONEY_W-1:0] money,
    output logic               boost,
    output logic [MONEY_W-1:0] credit,
    output logic [2:0]         state
);

    localparam int               CNT_W     = (OVER_CYC > 1) ? $clog2(OVER_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVER_CYC - 1);
    localparam logic [MONEY_W:0] MAX_EXT   = (MONEY_W + 1)'(MAX_CREDIT);
    localparam logic [MONEY_W-1:0] MIN_VAL = MONEY_W'(MIN_START);

    state_e             state_q, state_d;
    logic [MONEY_W-1:0] money_q, money_d;
    logic               boost_q, boost_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clr;
    logic [MONEY_W:0]   topup_sum;
    logic [MONEY_W-1:0] topup;

    game_credit_acc #(
        .MONEY_W    (MONEY_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .add    (coin_value(coin1, coin5)),
        .credit (credit)
    );

    // Top-up sum is one bit wider so it can be clamped instead of wrapping.
    always_comb begin
        topup_sum = {1'b0, remain} + {1'b0, credit};
        topup     = (topup_sum > MAX_EXT) ? MAX_EXT[MONEY_W-1:0] : topup_sum[MONEY_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        money_d = money_q;
        boost_d = 1'b0;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (credit >= MIN_VAL)) begin
                    state_d = ST_LOAD;
                    money_d = credit;
                    clr     = 1'b1;
                end
            end
            ST_LOAD: state_d = ST_ARM;
            ST_ARM:  state_d = ST_PLAY;
            ST_PLAY: begin
                // red wins over a top-up request; boost is only kept while play continues.
                if (red) begin
                    state_d = ST_OVER;
                    cnt_d   = '0;
                end else if (start && (credit != '0)) begin
                    state_d = ST_LOAD;
                    money_d = topup;
                    clr     = 1'b1;
                end else begin
                    boost_d = boost_req & ~yellow;
                end
            end
            ST_OVER: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            money_q <= '0;
            boost_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            money_q <= money_d;
            boost_q <= boost_d;
            cnt_q   <= cnt_d;
        end
    end

    assign set   = (state_q == ST_LOAD);
    assign money = money_q;
    assign boost = boost_q;
    assign state = state_q;

endmodule
